// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// instruction field codes, ALU control codes and datapath select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  // ALU_Control codes, also decoded by the ALU itself
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for opcodes that take the branch path through DECODE
  function automatic logic is_branch_op(input logic [5:0] opcode);
    logic hit;
    hit = (opcode == OP_BEQ);
`ifdef MIPS_CTRL_BNE_EN
    hit = hit | (opcode == OP_BNE);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface mips_ctrl_if #(
  parameter int OPC_W = 6,
  parameter int FN_W  = 6
);
  logic [OPC_W-1:0] Opcode;
  logic [FN_W-1:0]  Funct;
  logic             Zero_Flag;
  logic             PC_En;
  logic             IorD;
  logic             Mem_Write;
  logic             IR_Write;
  logic             Reg_Dst;
  logic             MemtoReg;
  logic             Reg_Write;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALU_Control;
  logic [1:0]       PCSrc;
  logic             Illegal_Instr;

  modport master (
    input  Opcode, Funct, Zero_Flag,
    output PC_En, IorD, Mem_Write, IR_Write, Reg_Dst, MemtoReg, Reg_Write,
           ALUSrcA, ALUSrcB, ALU_Control, PCSrc, Illegal_Instr
  );

  modport slave (
    output Opcode, Funct, Zero_Flag,
    input  PC_En, IorD, Mem_Write, IR_Write, Reg_Dst, MemtoReg, Reg_Write,
           ALUSrcA, ALUSrcB, ALU_Control, PCSrc, Illegal_Instr
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// ALU control decoder: maps alu_op (add/sub/funct) and the R-type funct field
// to an ALU_Control code; funct_valid flags supported R-type functs.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  logic [2:0] fn_ctrl_s;

  // Funct field decode, independent of alu_op so DECODE can check legality
  always_comb begin
    fn_ctrl_s   = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  fn_ctrl_s = ALU_ADD;
      FN_SUB:  fn_ctrl_s = ALU_SUB;
      FN_AND:  fn_ctrl_s = ALU_AND;
      FN_OR:   fn_ctrl_s = ALU_OR;
      FN_SLT:  fn_ctrl_s = ALU_SLT;
      FN_MUL:  fn_ctrl_s = ALU_MUL;
      default: begin
        fn_ctrl_s   = ALU_ADD;
        funct_valid = 1'b0;
      end
    endcase
  end

  // Operation select
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = fn_ctrl_s;
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore FSM controller for the multicycle MIPS datapath.
// Optional BNE support: define MIPS_CTRL_BNE_EN.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int FN_W  = 6
) (
  input  logic          CLK,
  input  logic          RST,
  mips_ctrl_if.master   bus
);

  state_e           state_r;
  state_e           next_state_s;
  logic [OPC_W-1:0] opcode_s;
  logic [FN_W-1:0]  funct_s;

  logic       pc_write_s;
  logic       branch_s;
  logic       branch_cond_s;
  logic       iord_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_dst_s;
  logic       memto_reg_s;
  logic       reg_write_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [1:0] pc_src_s;
  logic       illegal_s;
  logic [2:0] alu_control_s;
  logic       funct_valid_s;

  assign opcode_s = bus.Opcode;
  assign funct_s  = bus.Funct;

  mips_alu_decoder u_alu_dec (
    .funct       (funct_s),
    .alu_op      (alu_op_s),
    .alu_control (alu_control_s),
    .funct_valid (funct_valid_s)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state strobe decode
  always_comb begin
    next_state_s = S_FETCH;
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    iord_s       = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    memto_reg_s  = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = SRCB_B;
    alu_op_s     = ALUOP_ADD;
    pc_src_s     = PCSRC_ALU;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        alu_src_b_s  = SRCB_FOUR;
        ir_write_s   = 1'b1;
        pc_write_s   = 1'b1;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_s = SRCB_IMM_SH;
        if (is_branch_op(opcode_s)) begin
          next_state_s = S_BRANCH;
        end else begin
          case (opcode_s)
            OP_LW, OP_SW: next_state_s = S_MEMADR;
            OP_ADDI:      next_state_s = S_ADDIEX;
            OP_J:         next_state_s = S_JUMP;
            OP_R: begin
              if (funct_valid_s) begin
                next_state_s = S_EXEC;
              end else begin
                illegal_s    = 1'b1;
                next_state_s = S_FETCH;
              end
            end
            default: begin
              illegal_s    = 1'b1;
              next_state_s = S_FETCH;
            end
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = SRCB_IMM;
        next_state_s = (opcode_s == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_s       = 1'b1;
        next_state_s = S_MEMWB;
      end
      S_MEMWB: begin
        memto_reg_s = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        iord_s      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALUOP_SUB;
        pc_src_s    = PCSRC_ALUOUT;
        branch_s    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = SRCB_IMM;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
      end
      S_JUMP: begin
        pc_src_s   = PCSRC_JUMP;
        pc_write_s = 1'b1;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Branch condition; only meaningful while branch_s is high
  always_comb begin
    branch_cond_s = bus.Zero_Flag;
`ifdef MIPS_CTRL_BNE_EN
    if (opcode_s == OP_BNE) begin
      branch_cond_s = ~bus.Zero_Flag;
    end else begin
      branch_cond_s = bus.Zero_Flag;
    end
`endif
  end

  // Output stage: reset forces every strobe low regardless of state
  always_comb begin
    if (RST) begin
      bus.PC_En         = 1'b0;
      bus.IorD          = 1'b0;
      bus.Mem_Write     = 1'b0;
      bus.IR_Write      = 1'b0;
      bus.Reg_Dst       = 1'b0;
      bus.MemtoReg      = 1'b0;
      bus.Reg_Write     = 1'b0;
      bus.ALUSrcA       = 1'b0;
      bus.ALUSrcB       = 2'b00;
      bus.ALU_Control   = 3'b000;
      bus.PCSrc         = 2'b00;
      bus.Illegal_Instr = 1'b0;
    end else begin
      bus.PC_En         = pc_write_s | (branch_s & branch_cond_s);
      bus.IorD          = iord_s;
      bus.Mem_Write     = mem_write_s;
      bus.IR_Write      = ir_write_s;
      bus.Reg_Dst       = reg_dst_s;
      bus.MemtoReg      = memto_reg_s;
      bus.Reg_Write     = reg_write_s;
      bus.ALUSrcA       = alu_src_a_s;
      bus.ALUSrcB       = alu_src_b_s;
      bus.ALU_Control   = (state_r > S_JUMP) ? 3'b000 : alu_control_s;
      bus.PCSrc         = pc_src_s;
      bus.Illegal_Instr = illegal_s;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: stimulus pushes the expected
// output word per cycle, a negedge monitor pops and compares.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_ctrl_if bus ();

  mips_multicycle_control dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  logic [15:0] exp_q[$];
  string       name_q[$];
  int          tests  = 0;
  int          failed = 0;

  logic [15:0] obs;
  assign obs = {bus.PC_En, bus.IorD, bus.Mem_Write, bus.IR_Write, bus.Reg_Dst,
                bus.MemtoReg, bus.Reg_Write, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALU_Control, bus.PCSrc, bus.Illegal_Instr};

  function automatic logic [15:0] mk(input logic pc_en, input logic iord,
      input logic memw, input logic irw, input logic regdst, input logic m2r,
      input logic regw, input logic srca, input logic [1:0] srcb,
      input logic [2:0] aluc, input logic [1:0] pcsrc, input logic ill);
    return {pc_en, iord, memw, irw, regdst, m2r, regw, srca, srcb, aluc, pcsrc, ill};
  endfunction

  logic [15:0] e_zero, e_fetch, e_decode, e_dec_ill, e_memadr, e_memrd, e_memwb;
  logic [15:0] e_memwr, e_aluwb, e_br_t, e_br_n, e_addiex, e_addiwb, e_jump;

  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic [15:0] e, input string nm);
    @(posedge clk);
    #1;
    rst           = r;
    bus.Opcode    = op;
    bus.Funct     = fn;
    bus.Zero_Flag = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic run_r(input logic [5:0] fn, input logic [2:0] aluc);
    step(1'b0, 6'b000000, fn, 1'b0, e_fetch,  "r_fetch");
    step(1'b0, 6'b000000, fn, 1'b0, e_decode, "r_decode");
    step(1'b0, 6'b000000, fn, 1'b0,
         mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,aluc,2'b00,1'b0), "r_exec");
    step(1'b0, 6'b000000, fn, 1'b0, e_aluwb,  "r_aluwb");
  endtask

  task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn);
    step(1'b0, op, fn, 1'b0, e_fetch,   "ill_fetch");
    step(1'b0, op, fn, 1'b0, e_dec_ill, "ill_decode");
  endtask

  task automatic run_branch(input logic [5:0] op, input logic z, input logic [15:0] e_br);
    step(1'b0, op, 6'b000000, z, e_fetch,  "br_fetch");
    step(1'b0, op, 6'b000000, z, e_decode, "br_decode");
    step(1'b0, op, 6'b000000, z, e_br,     "br_branch");
  endtask

  // Monitor: one output word per cycle, compared mid-cycle
  initial begin
    logic [15:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        tests++;
        if (obs !== e) begin
          failed++;
          $display("FAIL %s: got %b expected %b (t=%0t)", nm, obs, e, $time);
        end
      end
    end
  end

  initial begin
    logic [5:0] fns   [6];
    logic [2:0] alucs [6];
    fns   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000};
    alucs = '{3'b010,    3'b100,    3'b000,    3'b001,    3'b110,    3'b101};

    e_zero    = 16'h0000;
    e_fetch   = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b010,2'b00,1'b0);
    e_decode  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b010,2'b00,1'b0);
    e_dec_ill = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b010,2'b00,1'b1);
    e_memadr  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,2'b00,1'b0);
    e_memrd   = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b010,2'b00,1'b0);
    e_memwb   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b010,2'b00,1'b0);
    e_memwr   = mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b010,2'b00,1'b0);
    e_aluwb   = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b010,2'b00,1'b0);
    e_br_t    = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b100,2'b01,1'b0);
    e_br_n    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b100,2'b01,1'b0);
    e_addiex  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,2'b00,1'b0);
    e_addiwb  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b010,2'b00,1'b0);
    e_jump    = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b010,2'b10,1'b0);

    bus.Opcode    = 6'b000000;
    bus.Funct     = 6'b000000;
    bus.Zero_Flag = 1'b0;

    // Reset for two cycles; outputs forced low
    step(1'b1, 6'b000000, 6'b100010, 1'b0, e_zero, "rst_c0");
    step(1'b1, 6'b000000, 6'b100010, 1'b0, e_zero, "rst_c1");

    // R-type, all functs; SUB comes right after reset release
    run_r(fns[1], alucs[1]);
    for (int i = 0; i < 6; i++) run_r(fns[i], alucs[i]);

    // LW: 5 cycles
    step(1'b0, 6'b100011, 6'b000000, 1'b0, e_fetch,  "lw_fetch");
    step(1'b0, 6'b100011, 6'b000000, 1'b0, e_decode, "lw_decode");
    step(1'b0, 6'b100011, 6'b000000, 1'b0, e_memadr, "lw_memadr");
    step(1'b0, 6'b100011, 6'b000000, 1'b0, e_memrd,  "lw_memrd");
    step(1'b0, 6'b100011, 6'b000000, 1'b0, e_memwb,  "lw_memwb");

    // SW: 4 cycles, single Mem_Write cycle
    step(1'b0, 6'b101011, 6'b000000, 1'b0, e_fetch,  "sw_fetch");
    step(1'b0, 6'b101011, 6'b000000, 1'b0, e_decode, "sw_decode");
    step(1'b0, 6'b101011, 6'b000000, 1'b0, e_memadr, "sw_memadr");
    step(1'b0, 6'b101011, 6'b000000, 1'b0, e_memwr,  "sw_memwr");

    // BEQ taken / not taken
    run_branch(6'b000100, 1'b1, e_br_t);
    run_branch(6'b000100, 1'b0, e_br_n);

`ifdef MIPS_CTRL_BNE_EN
    run_branch(6'b000101, 1'b0, e_br_t);
    run_branch(6'b000101, 1'b1, e_br_n);
`else
    run_illegal(6'b000101, 6'b000000);
`endif

    // ADDI: 4 cycles
    step(1'b0, 6'b001000, 6'b000000, 1'b0, e_fetch,  "addi_fetch");
    step(1'b0, 6'b001000, 6'b000000, 1'b0, e_decode, "addi_decode");
    step(1'b0, 6'b001000, 6'b000000, 1'b0, e_addiex, "addi_ex");
    step(1'b0, 6'b001000, 6'b000000, 1'b0, e_addiwb, "addi_wb");

    // J: 3 cycles
    step(1'b0, 6'b000010, 6'b000000, 1'b0, e_fetch,  "j_fetch");
    step(1'b0, 6'b000010, 6'b000000, 1'b0, e_decode, "j_decode");
    step(1'b0, 6'b000010, 6'b000000, 1'b0, e_jump,   "j_jump");

    // Illegal opcode and illegal R funct: 2 cycles each
    run_illegal(6'b111111, 6'b100000);
    run_illegal(6'b000000, 6'b000111);

    // LW aborted by reset in MEMRD: no write-back, FETCH after release
    step(1'b0, 6'b100011, 6'b000000, 1'b0, e_fetch,  "lwa_fetch");
    step(1'b0, 6'b100011, 6'b000000, 1'b0, e_decode, "lwa_decode");
    step(1'b0, 6'b100011, 6'b000000, 1'b0, e_memadr, "lwa_memadr");
    step(1'b1, 6'b100011, 6'b000000, 1'b0, e_zero,   "lwa_rst");
    step(1'b0, 6'b100011, 6'b000000, 1'b0, e_fetch,  "lwa_refetch");
    step(1'b0, 6'b100011, 6'b000000, 1'b0, e_decode, "lwa_redecode");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
